// File: rtl/usr_cmd_seq_if.sv
// Command channel between an upstream controller and usr_cmd_seq.
// The master side presents a command; the slave accepts it when cmd_valid and cmd_ready are both high.
interface usr_cmd_seq_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic             cmd_fill;
    logic [WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid, cmd_op, cmd_cnt, cmd_fill, cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_cnt, cmd_fill, cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/usr_cmd_seq.sv
// usr_cmd_seq: command sequencer for the universal shift register.
// It accepts hold, shift-left, shift-right and load commands. It then drives the USR control pins for the requested number of cycles.
// A one-cycle done pulse marks the end of each command.
// Optional build macro USR_SEQ_ROTATE_EN: adds the usr_q input. Shift fill bits then come combinationally from the USR output, which turns each shift into a rotate.
module usr_cmd_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    usr_cmd_seq_if.slave     cmd,
    output logic [1:0]       usr_sel,
    output logic             usr_s_left,
    output logic             usr_s_right,
    output logic [WIDTH-1:0] usr_p_in,
`ifdef USR_SEQ_ROTATE_EN
    input  logic [WIDTH-1:0] usr_q,
`endif
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_SHL  = 2'b01;
    localparam logic [1:0] OP_SHR  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [1:0]       op_q, op_nxt;
    logic             accept;

    logic             ready_nxt, busy_nxt, done_nxt;
    logic [1:0]       sel_nxt;
    logic [WIDTH-1:0] p_in_nxt;

    // cmd_ready is registered as "state == IDLE", so testing the state directly gives the same handshake.
    assign accept = (state == IDLE) && cmd.cmd_valid;

    // State register: FSM state, down-counter and captured opcode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt_q <= '0;
            op_q  <= OP_HOLD;
        end else begin
            state <= state_nxt;
            cnt_q <= cnt_nxt;
            op_q  <= op_nxt;
        end
    end

    // Next-state logic: a load counts as one RUN cycle, and a zero count skips RUN.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        op_nxt    = op_q;
        case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    op_nxt = cmd.cmd_op;
                    if (cmd.cmd_op == OP_LOAD) begin
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = RUN;
                    end else begin
                        cnt_nxt   = cmd.cmd_cnt;
                        state_nxt = (cmd.cmd_cnt == '0) ? DONE : RUN;
                    end
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the next state, so that the registered outputs line up with the state they describe.
    always_comb begin
        ready_nxt = (state_nxt == IDLE);
        busy_nxt  = (state_nxt != IDLE);
        done_nxt  = (state_nxt == DONE);
        sel_nxt   = (state_nxt == RUN) ? op_nxt : OP_HOLD;
        p_in_nxt  = (accept && cmd.cmd_op == OP_LOAD) ? cmd.cmd_data : usr_p_in;
    end

    // Output registers for the handshake, status and USR control pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd.cmd_ready <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            usr_sel       <= OP_HOLD;
            usr_p_in      <= '0;
        end else begin
            cmd.cmd_ready <= ready_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            usr_sel       <= sel_nxt;
            usr_p_in      <= p_in_nxt;
        end
    end

`ifdef USR_SEQ_ROTATE_EN
    // Rotate fill: feed the bit that is shifted out back in. The fill is gated by the registered sel, so it is zero outside shift cycles in that direction.
    always_comb begin
        usr_s_left  = (usr_sel == OP_SHL) ? usr_q[WIDTH-1] : 1'b0;
        usr_s_right = (usr_sel == OP_SHR) ? usr_q[0]       : 1'b0;
    end
`else
    logic fill_q;
    logic fill_eff;
    logic s_left_nxt, s_right_nxt;

    // Capture the serial fill bit on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q <= 1'b0;
        end else if (accept) begin
            fill_q <= cmd.cmd_fill;
        end
    end

    // Serial fill decode: the fill is presented only on the pin that matches the shift direction.
    always_comb begin
        fill_eff    = accept ? cmd.cmd_fill : fill_q;
        s_left_nxt  = (state_nxt == RUN) && (op_nxt == OP_SHL) && fill_eff;
        s_right_nxt = (state_nxt == RUN) && (op_nxt == OP_SHR) && fill_eff;
    end

    // Registered serial fill outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            usr_s_left  <= 1'b0;
            usr_s_right <= 1'b0;
        end else begin
            usr_s_left  <= s_left_nxt;
            usr_s_right <= s_right_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_usr_cmd_seq.sv
// Scoreboard bench for usr_cmd_seq driving a behavioural 4-bit USR.
// Define USR_SEQ_ROTATE_EN to exercise the rotate build.
module tb_usr_cmd_seq;
    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    usr_cmd_seq_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    logic [1:0]       usr_sel;
    logic             usr_s_left, usr_s_right, busy, done;
    logic [WIDTH-1:0] usr_p_in;
    logic [WIDTH-1:0] usr_q;

    usr_cmd_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (bus),
        .usr_sel     (usr_sel),
        .usr_s_left  (usr_s_left),
        .usr_s_right (usr_s_right),
        .usr_p_in    (usr_p_in),
`ifdef USR_SEQ_ROTATE_EN
        .usr_q       (usr_q),
`endif
        .busy        (busy),
        .done        (done)
    );

    // Downstream universal shift register.
    always @(posedge clk) begin
        case (usr_sel)
            2'b01:   usr_q <= {usr_q[WIDTH-2:0], usr_s_left};
            2'b10:   usr_q <= {usr_s_right, usr_q[WIDTH-1:1]};
            2'b11:   usr_q <= usr_p_in;
            default: usr_q <= usr_q;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        string      name;
        logic [1:0] op;
        int         nrun;
        int         lat;
        logic       sl;
        logic       sr;
        logic [3:0] out;
        logic [3:0] pin;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t mk(input string name, input logic [1:0] op, input int nrun, input int lat,
                                input logic sl, input logic sr, input logic [3:0] out, input logic [3:0] pin);
        exp_t e;
        e.name = name; e.op = op; e.nrun = nrun; e.lat = lat;
        e.sl = sl; e.sr = sr; e.out = out; e.pin = pin;
        return e;
    endfunction

    // Monitor: checks the pins on every RUN cycle, and pops and compares one record on each done pulse.
    initial begin : monitor
        int   acc_cyc;
        int   run_n;
        bit   ready_chk;
        logic esl, esr;
        exp_t e;
        acc_cyc = 0; run_n = 0; ready_chk = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run_n = 0;
                ready_chk = 0;
                continue;
            end
            if (ready_chk) begin
                chk("ready_back", {31'd0, bus.cmd_ready}, 32'd1);
                ready_chk = 0;
            end
            if (!busy)
                chk("idle_pins", {29'd0, usr_sel, usr_s_left ^ usr_s_right}, 32'd0);
            if (bus.cmd_valid && bus.cmd_ready) begin
                acc_cyc = cyc;
                run_n = 0;
            end
            if (busy && !done) begin
                run_n++;
                if (sb.size() > 0) begin
`ifdef USR_SEQ_ROTATE_EN
                    esl = (sb[0].op == 2'b01) ? usr_q[3] : 1'b0;
                    esr = (sb[0].op == 2'b10) ? usr_q[0] : 1'b0;
`else
                    esl = sb[0].sl;
                    esr = sb[0].sr;
`endif
                    chk({sb[0].name, "_run_pins"}, {28'd0, usr_sel, usr_s_left, usr_s_right},
                        {28'd0, sb[0].op, esl, esr});
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected no pending command (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_latency"}, cyc - acc_cyc, e.lat);
                    chk({e.name, "_run_cycles"}, run_n, e.nrun);
                    chk({e.name, "_usr_out"}, {28'd0, usr_q}, {28'd0, e.out});
                    chk({e.name, "_p_in"}, {28'd0, usr_p_in}, {28'd0, e.pin});
                    chk({e.name, "_done_pins"}, {27'd0, bus.cmd_ready, busy, usr_sel, usr_s_left | usr_s_right},
                        {27'd0, 1'b0, 1'b1, 2'b00, 1'b0});
                    ready_chk = 1;
                end
            end
        end
    end

    // Presents one command and holds it until accepted. On return the accepting edge has just passed.
    task automatic send(input logic [1:0] op, input logic [2:0] n, input logic fill, input logic [3:0] data,
                        input exp_t e, input bit push, input bit keep, output int waits);
        if (push) sb.push_back(e);
        bus.cmd_op    = op;
        bus.cmd_cnt   = n;
        bus.cmd_fill  = fill;
        bus.cmd_data  = data;
        bus.cmd_valid = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (bus.cmd_ready) break;
            waits++;
            if (waits > 40) begin
                $display("FAIL accept_timeout: got no cmd_ready expected accept within 40 cycles");
                bad++;
                total++;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!keep) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(sb.size() == 0 && bus.cmd_ready && !busy)) begin
            @(negedge clk);
            n++;
            if (n > 40) begin
                $display("FAIL idle_timeout: got busy expected idle within 40 cycles");
                bad++;
                total++;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no finish expected finish by 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int w;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'b00; bus.cmd_cnt = '0; bus.cmd_fill = 1'b0; bus.cmd_data = '0;
        #13;
        chk("reset_state", {23'd0, bus.cmd_ready, busy, done, usr_sel, usr_s_left, usr_s_right, usr_p_in},
            {23'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000});
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

`ifdef USR_SEQ_ROTATE_EN
        send(2'b11, 3'd0, 1'b1, 4'b1000, mk("rot_load", 2'b11, 1, 2, 0, 0, 4'b1000, 4'b1000), 1, 0, w);
        wait_idle();
        send(2'b01, 3'd1, 1'b0, 4'b0000, mk("rotl1", 2'b01, 1, 2, 0, 0, 4'b0001, 4'b1000), 1, 0, w);
        wait_idle();
        send(2'b10, 3'd3, 1'b1, 4'b0000, mk("rotr3", 2'b10, 3, 4, 0, 0, 4'b0010, 4'b1000), 1, 0, w);
        wait_idle();
        send(2'b01, 3'd2, 1'b1, 4'b0000, mk("rotl2", 2'b01, 2, 3, 0, 0, 4'b1000, 4'b1000), 1, 0, w);
        wait_idle();
        send(2'b01, 3'd0, 1'b1, 4'b0000, mk("rot_cnt0", 2'b01, 0, 1, 0, 0, 4'b1000, 4'b1000), 1, 0, w);
        wait_idle();
        send(2'b00, 3'd3, 1'b1, 4'b0000, mk("rot_hold3", 2'b00, 3, 4, 0, 0, 4'b1000, 4'b1000), 1, 0, w);
        wait_idle();
        send(2'b11, 3'd4, 1'b0, 4'b1010, mk("b2b_load", 2'b11, 1, 2, 0, 0, 4'b1010, 4'b1010), 1, 1, w);
        send(2'b01, 3'd2, 1'b0, 4'b0000, mk("b2b_rotl2", 2'b01, 2, 3, 0, 0, 4'b1010, 4'b1010), 1, 0, w);
        chk("b2b_wait", w, 2);
        wait_idle();
`else
        send(2'b11, 3'd0, 1'b0, 4'b0100, mk("load0100", 2'b11, 1, 2, 0, 0, 4'b0100, 4'b0100), 1, 0, w);
        wait_idle();
        send(2'b01, 3'd1, 1'b1, 4'b0000, mk("shl1_f1", 2'b01, 1, 2, 1, 0, 4'b1001, 4'b0100), 1, 0, w);
        wait_idle();
        send(2'b10, 3'd2, 1'b0, 4'b0000, mk("shr2_f0", 2'b10, 2, 3, 0, 0, 4'b0010, 4'b0100), 1, 0, w);
        wait_idle();
        send(2'b01, 3'd0, 1'b1, 4'b0000, mk("shl_cnt0", 2'b01, 0, 1, 0, 0, 4'b0010, 4'b0100), 1, 0, w);
        wait_idle();
        send(2'b00, 3'd3, 1'b1, 4'b1111, mk("hold3", 2'b00, 3, 4, 0, 0, 4'b0010, 4'b0100), 1, 0, w);
        wait_idle();
        send(2'b11, 3'd5, 1'b0, 4'b1010, mk("b2b_load", 2'b11, 1, 2, 0, 0, 4'b1010, 4'b1010), 1, 1, w);
        send(2'b01, 3'd2, 1'b0, 4'b0000, mk("b2b_shl2", 2'b01, 2, 3, 0, 0, 4'b1000, 4'b1010), 1, 0, w);
        chk("b2b_wait", w, 2);
        wait_idle();
        send(2'b10, 3'd3, 1'b1, 4'b0000, mk("shr3_f1", 2'b10, 3, 4, 0, 1, 4'b1111, 4'b1010), 1, 0, w);
        wait_idle();
`endif

        // Abort a 5-cycle shift during its second RUN cycle.
        send(2'b01, 3'd5, 1'b1, 4'b0000, mk("abort", 2'b01, 5, 6, 1, 0, 4'b0000, 4'b0000), 0, 0, w);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_reset_pins", {23'd0, bus.cmd_ready, busy, done, usr_sel, usr_s_left, usr_s_right, usr_p_in},
            {23'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000});
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done}, 32'd0);
        end
        @(posedge clk);
        #1;
        send(2'b11, 3'd0, 1'b0, 4'b0011, mk("post_rst_load", 2'b11, 1, 2, 0, 0, 4'b0011, 4'b0011), 1, 0, w);
        chk("post_rst_first_accept", w, 0);
        wait_idle();
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
